icache_axi_rd_bridge: RTL and testbench

Read-side responder for the instruction cache's refill port. It accepts a single cache-line or uncached read request (r_req/r_addr/r_length), issues it as one AXI4 INCR burst on the AR channel, and returns the R-channel beats to the cache as ret_valid/ret_last/r_data through a one-entry output register with backpressure from r_data_ready. It sits between the icache and the top-level AXI crossbar, one instance per icache.

---
 rtl/icache_axi_rd_bridge.sv | 124 ++++++++++++
 tb/tb_icache_axi_rd_bridge.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/icache_axi_rd_bridge.sv
// Icache refill read bridge: turns one cache read request into a single AXI4 INCR burst
// and returns the R beats through a one-entry output register with backpressure.
module icache_axi_rd_bridge #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_req,
  input  logic [31:0] r_addr,
  input  logic [7:0]  r_length,
  output logic        r_rdy,
  input  logic        r_data_ready,
  output logic        ret_valid,
  output logic        ret_last,
  output logic [31:0] r_data,
  output logic        ret_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  state_t      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        buf_full_q, buf_full_d;
  logic [31:0] data_q, data_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  logic accept, beat, pop, int_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      araddr_q   <= '0;
      arlen_q    <= '0;
      cnt_q      <= '0;
      buf_full_q <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      cnt_q      <= cnt_d;
      buf_full_q <= buf_full_d;
      data_q     <= data_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  // Counter is compared before it increments, so arlen = 255 still ends on beat 255.
  assign int_last = (cnt_q == arlen_q);
  assign accept   = r_req & r_rdy;
  assign beat     = rvalid & rready;
  assign pop      = buf_full_q & r_data_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_AR;
      S_AR:    if (arready) state_d = S_R;
      S_R:     if (pop && last_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    cnt_d      = cnt_q;
    buf_full_d = buf_full_q;
    data_d     = data_q;
    last_d     = last_q;
    err_d      = err_q;
    if (accept) begin
      araddr_d = r_addr;
      arlen_d  = r_length;
      cnt_d    = '0;
      err_d    = 1'b0;
    end
    // A beat arriving alongside a pop takes the buffer, so load wins over clear.
    if (beat) begin
      data_d     = rdata;
      last_d     = int_last;
      cnt_d      = cnt_q + 8'd1;
      buf_full_d = 1'b1;
      if ((rlast != int_last) || (rresp != 2'b00)) err_d = 1'b1;
    end else if (pop) begin
      buf_full_d = 1'b0;
    end
  end

  always_comb begin
    r_rdy     = (state_q == S_IDLE) & ~rst;
    arvalid   = (state_q == S_AR);
    rready    = (state_q == S_R) & (~buf_full_q | r_data_ready);
    ret_valid = buf_full_q;
    ret_last  = buf_full_q & last_q;
    r_data    = data_q;
    ret_err   = err_q;
    arid      = AXI_ID;
    araddr    = araddr_q;
    arlen     = arlen_q;
    arsize    = 3'b010;
    arburst   = 2'b01;
  end

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed bench for icache_axi_rd_bridge: line fill, single beat, backpressure,
// error reporting, rlast mismatch and reset mid-burst.
module tb_icache_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_req;
  logic [31:0] r_addr;
  logic [7:0]  r_length;
  logic        r_rdy;
  logic        r_data_ready;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] r_data;
  logic        ret_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int tests = 0;
  int fails = 0;
  logic prev_err = 1'b0;

  icache_axi_rd_bridge dut (
    .clk(clk), .rst(rst), .r_req(r_req), .r_addr(r_addr), .r_length(r_length),
    .r_rdy(r_rdy), .r_data_ready(r_data_ready), .ret_valid(ret_valid),
    .ret_last(ret_last), .r_data(r_data), .ret_err(ret_err), .arid(arid),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_r_rdy"}, r_rdy, 0);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_ret_valid"}, ret_valid, 0);
    chk({tag, "_ret_last"}, ret_last, 0);
    chk({tag, "_ret_err"}, ret_err, 0);
    chk({tag, "_r_data"}, r_data, 0);
    chk({tag, "_araddr"}, araddr, 0);
    chk({tag, "_arlen"}, arlen, 0);
  endtask

  // One request end to end; the bench plays the AXI slave. stall_mask bit c drops
  // r_data_ready in R-phase cycle c. abort_pops >= 0 leaves the burst after that many pops.
  task automatic burst(input logic [31:0] addr, input int len, input int ar_wait,
                       input int err_beat, input int rlast_beat, input logic [31:0] stall_mask,
                       input logic [31:0] data_base, input int exp_cycles, input int abort_pops);
    int b = 0;
    int exp = 0;
    int cyc = 0;
    int pops = 0;
    logic done = 1'b0;
    logic err_flag = 1'b0;
    logic load_err;

    @(posedge clk); #1;
    r_req = 1'b1; r_addr = addr; r_length = len[7:0];
    @(negedge clk);
    chk("accept_r_rdy", r_rdy, 1);
    chk("sticky_err_before_accept", ret_err, prev_err);
    @(posedge clk); #1;
    r_req = 1'b0; r_addr = 32'hDEAD_BEEF; r_length = 8'hAA;

    for (int w = 0; w <= ar_wait; w++) begin
      arready = (w == ar_wait);
      @(negedge clk);
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, addr);
      chk("arlen", arlen, len);
      chk("arsize", arsize, 2);
      chk("arburst", arburst, 1);
      chk("arid", arid, 0);
      chk("r_rdy_busy", r_rdy, 0);
      chk("err_cleared", ret_err, 0);
      @(posedge clk); #1;
    end
    arready = 1'b0;

    while (!done && cyc < 300) begin
      rvalid = (b <= len);
      rdata  = data_base + b;
      rlast  = (b == rlast_beat);
      rresp  = (b == err_beat) ? 2'b10 : 2'b00;
      r_data_ready = ~stall_mask[cyc % 32];
      @(negedge clk);
      chk("rready", rready, !(ret_valid && !r_data_ready));
      chk("ret_err", ret_err, err_flag);
      if (ret_valid) begin
        chk("r_data", r_data, data_base + exp);
        chk("ret_last", ret_last, exp == len);
      end else begin
        chk("ret_last_idle", ret_last, 0);
      end
      load_err = 1'b0;
      if (rvalid && rready) begin
        if ((b == err_beat) || ((b == rlast_beat) != (b == len))) load_err = 1'b1;
        b++;
      end
      if (ret_valid && r_data_ready) begin
        if (ret_last) done = 1'b1;
        exp++;
        pops++;
      end
      if (abort_pops >= 0 && pops == abort_pops) return;
      @(posedge clk); #1;
      if (load_err) err_flag = 1'b1;
      cyc++;
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; r_data_ready = 1'b1;
    if (!done) chk("burst_timeout", 0, 1);
    chk("beats_popped", pops, len + 1);
    if (exp_cycles >= 0) chk("r_phase_cycles", cyc, exp_cycles);
    @(negedge clk);
    chk("r_rdy_after_last", r_rdy, 1);
    chk("ret_valid_after_last", ret_valid, 0);
    chk("ret_err_hold", ret_err, err_flag);
    prev_err = err_flag;
  endtask

  initial begin
    rst = 1'b1; r_req = 1'b0; r_addr = '0; r_length = '0; r_data_ready = 1'b1;
    arready = 1'b0; rid = 4'h3; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("r_rdy_after_por", r_rdy, 1);

    burst(32'h1C00_0040, 15, 0, -1, 15, 32'h0, 32'h0, 17, -1);
    burst(32'h1C00_0100, 0, 5, -1, 0, 32'h0, 32'hA5A5_0000, 2, -1);
    burst(32'h1C00_0200, 7, 1, -1, 7, 32'h6, 32'h100, 11, -1);
    burst(32'h1C00_0300, 3, 0, 3, 3, 32'h0, 32'h200, 5, -1);
    burst(32'h1C00_0400, 3, 0, -1, 1, 32'h0, 32'h300, 5, -1);

    burst(32'h1C00_0500, 15, 0, -1, 15, 32'h0, 32'h400, -1, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("r_rdy_after_mid_rst", r_rdy, 1);
    prev_err = 1'b0;

    burst(32'h1C00_0600, 15, 2, -1, 15, 32'h0, 32'h500, 17, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
